// File: rtl/chacha_core_param.sv
`default_nettype none
// ============================================================================
// Module      : chacha_core_param
// Description : ChaCha block core with configurable rounds and number of
//               quarter-rounds evaluated per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_core_param #(
    parameter int ROUNDS = 20,
    parameter int QR_PAR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out,
    output logic         busy,
    output logic [15:0]  blocks_done
);

    generate
        if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
            $error("chacha_core_param: ROUNDS must be 8, 12 or 20");
        end
        if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_qr_par
            $error("chacha_core_param: QR_PAR must be 1, 2 or 4");
        end
    endgenerate

    localparam int c_groups = 8 / QR_PAR;
    localparam int c_steps  = (ROUNDS / 2) * c_groups;
    localparam int c_step_w = $clog2(c_steps);
    localparam int c_grp_w  = $clog2(c_groups);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_ADD   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_step_w-1:0]   r_step;
    logic [c_grp_w-1:0]    r_grp;
    logic [511:0]          r_init;
    logic [511:0]          r_work;
    logic [511:0]          r_out;
    logic                  r_valid;
    logic [15:0]           r_count;
    logic [511:0]          w_work_nxt;
    logic [511:0]          w_sum;
    logic                  w_last_step;
    logic [127:0]          w_lane_res [QR_PAR];
    logic [3:0]            w_lane_idx [QR_PAR][4];

    function automatic logic [127:0] quarter(input logic [31:0] a_i, input logic [31:0] b_i,
                                             input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b;  d = d ^ a;  d = {d[15:0], d[31:16]};
        c = c + d;  b = b ^ c;  b = {b[19:0], b[31:20]};
        a = a + b;  d = d ^ a;  d = {d[23:0], d[31:24]};
        c = c + d;  b = b ^ c;  b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    assign w_last_step = (r_step == c_step_w'(c_steps - 1));

    // QR index q in 0..7 walks a double round: 0-3 columns, 4-7 diagonals.
    // Groups are aligned to QR_PAR, so one group never straddles the two halves.
    generate
        for (genvar j = 0; j < QR_PAR; j++) begin : g_lane
            logic [2:0] w_q;
            logic [1:0] w_k;
            logic       w_diag;

            assign w_q    = 3'(r_grp * QR_PAR + j);
            assign w_k    = w_q[1:0];
            assign w_diag = w_q[2];

            assign w_lane_idx[j][0] = {2'd0, w_k};
            assign w_lane_idx[j][1] = {2'd1, w_k + {1'b0, w_diag}};
            assign w_lane_idx[j][2] = {2'd2, w_k + {w_diag, 1'b0}};
            assign w_lane_idx[j][3] = {2'd3, w_k + {w_diag, w_diag}};

            assign w_lane_res[j] = quarter(r_work[32*w_lane_idx[j][0] +: 32],
                                           r_work[32*w_lane_idx[j][1] +: 32],
                                           r_work[32*w_lane_idx[j][2] +: 32],
                                           r_work[32*w_lane_idx[j][3] +: 32]);
        end
    endgenerate

    always_comb begin
        w_work_nxt = r_work;
        for (int j = 0; j < QR_PAR; j++) begin
            for (int m = 0; m < 4; m++) begin
                w_work_nxt[32*w_lane_idx[j][m] +: 32] = w_lane_res[j][32*m +: 32];
            end
        end
    end

    generate
        for (genvar i = 0; i < 16; i++) begin : g_add
            assign w_sum[32*i +: 32] = r_work[32*i +: 32] + r_init[32*i +: 32];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_state_nxt = S_ROUND;
            S_ROUND: if (w_last_step) w_state_nxt = S_ADD;
            S_ADD:                    w_state_nxt = S_OUT;
            S_OUT:   if (out_ready)   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_grp   <= '0;
            r_init  <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_init <= state_in;
                        r_work <= state_in;
                        r_step <= '0;
                        r_grp  <= '0;
                    end
                end
                S_ROUND: begin
                    r_work <= w_work_nxt;
                    r_step <= r_step + 1'b1;
                    r_grp  <= (r_grp == c_grp_w'(c_groups - 1)) ? '0 : r_grp + 1'b1;
                end
                S_ADD: begin
                    r_out   <= w_sum;
                    r_valid <= 1'b1;
                end
                S_OUT: begin
                    // Output is cleared on handshake so it reads zero while invalid.
                    if (out_ready) begin
                        r_out   <= '0;
                        r_valid <= 1'b0;
                        r_count <= r_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = r_valid;
    assign state_out   = r_out;
    assign blocks_done = r_count;

endmodule
`default_nettype wire

// File: doc/chacha_core_param.md
CHACHA_CORE_PARAM -- requirements
Module: chacha_core_param

Interface
REQ-001 Parameter ROUNDS, default 20, total ChaCha rounds; legal values 8, 12, 20; any other value shall fail elaboration.
REQ-002 Parameter QR_PAR, default 1, quarter-rounds evaluated per clock; legal values 1, 2, 4; any other value shall fail elaboration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  state_in is valid.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 state_in  input  512  initial 4x4 state; word i (row i/4, column i%4) at bits [32i+31:32i].
REQ-008 out_valid  output  1  state_out holds a finished block.
REQ-009 out_ready  input  1  consumer accepts state_out.
REQ-010 state_out  output  512  keystream block, same word packing as state_in.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 blocks_done  output  16  count of completed output handshakes.

Function
REQ-013 FSM states: IDLE, ROUND, ADD, OUT; a single state register.
REQ-014 in_ready shall be 1 only in IDLE; in_valid outside IDLE is ignored.
REQ-015 Accept edge: IDLE with in_valid=1; registers state_in into both the initial copy and the working copy, clears step counter, moves to ROUND.
REQ-016 Quarter-round on (a,b,c,d), all mod 2^32: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7; fully combinational within one cycle.
REQ-017 Column QR k (k=0..3) uses words k, 4+k, 8+k, 12+k.
REQ-018 Diagonal QR k uses words k, 4+(k+1)%4, 8+(k+2)%4, 12+(k+3)%4.
REQ-019 Each double round = columns QR0..3, then diagonals QR0..3; each ROUND edge applies QR_PAR consecutive QRs of that sequence in parallel; a group never mixes columns with diagonals.
REQ-020 Each ROUND edge increments the step counter; after (ROUNDS/2)*(8/QR_PAR) ROUND edges the FSM moves to ADD.
REQ-021 ADD edge: registers state_out[i] = working[i] + initial[i] mod 2^32 for all 16 words, sets out_valid=1, moves to OUT.
REQ-022 Latency: out_valid high after exactly (ROUNDS/2)*(8/QR_PAR)+1 edges following the accept edge (81 for 20/1, 9 for 8/4).
REQ-023 OUT: state_out and out_valid held stable until out_ready=1; on that edge out_valid->0, blocks_done increments, FSM -> IDLE.
REQ-024 out_ready outside OUT has no effect; out_ready held 1 in advance completes the handshake on the first OUT cycle.
REQ-025 blocks_done wraps 0xFFFF -> 0x0000 without stall.
REQ-026 Minimum block period: latency + 2 cycles (OUT handshake, IDLE accept); no overlap of blocks.
REQ-027 state_out shall read 0 whenever out_valid=0.

Reset
REQ-028 rst_n=0 at any time, including mid-ROUND or in OUT, shall immediately force: FSM=IDLE, in_ready=1 after release, out_valid=0, busy=0, state_out=0, blocks_done=0, step counter=0, working/initial copies=0; the in-flight block is discarded, never output.
REQ-029 First accept is possible on the first rising edge with rst_n=1.

Verification
REQ-030 RFC 8439 2.3.2 vector (key 00..1f, counter 1, nonce 000000090000004a00000000), ROUNDS=20, QR_PAR=1,2,4 -> state_out word0=0xe4e7f110, word15=0x4e3c50a2, identical across QR_PAR; out_valid at edge 81/41/21 after accept.
REQ-031 Backpressure: out_ready=0 for 10 cycles in OUT -> state_out and out_valid unchanged, in_ready=0, blocks_done unchanged; then out_ready=1 -> blocks_done +1, IDLE next cycle.
REQ-032 in_valid pulsed with different state_in during ROUND -> ignored; output equals the originally accepted block.
REQ-033 rst_n low at ROUND step 37 -> out_valid=0, blocks_done=0, busy=0 at once; a fresh block after release yields correct result with nominal latency.
REQ-034 blocks_done preset via 65535 back-to-back blocks (ROUNDS=8, QR_PAR=4) -> wraps to 0 on the 65536th handshake.
REQ-035 Random state_in, all parameter combinations, compared against a software reference model; zero mismatches over 1000 blocks each.
